// File: rtl/gauss3x3_engine_if.sv
// ---------------------------------------------------------------------------
// gauss3x3_engine_if
//
// Purpose: bundles the sequencer handshake and both dual-port SRAM ports
// used by gauss3x3_engine into one interface.
//
// Signals:
//   start  sequencer -> engine  one-cycle run request
//   busy   engine -> sequencer  high while a frame is being filtered
//   done   engine -> sequencer  one-cycle pulse after the final write
//   ena    engine -> SRAM A     read-port enable
//   wena   engine -> SRAM A     read-port write enable (active-low, held 1)
//   addra  engine -> SRAM A     read address
//   qa     SRAM A -> engine     read data, valid the cycle after addra
//   enb    engine -> SRAM B     write-port enable
//   wenb   engine -> SRAM B     write enable (active-low)
//   addrb  engine -> SRAM B     write address
//   db     engine -> SRAM B     write data
//
// Modports: master = engine side, slave = sequencer/SRAM side.
// ---------------------------------------------------------------------------
interface gauss3x3_engine_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       ena;
    logic       wena;
    logic [9:0] addra;
    logic [7:0] qa;
    logic       enb;
    logic       wenb;
    logic [9:0] addrb;
    logic [7:0] db;

    modport master (
        input  start, qa,
        output busy, done, ena, wena, addra, enb, wenb, addrb, db
    );

    modport slave (
        output start, qa,
        input  busy, done, ena, wena, addra, enb, wenb, addrb, db
    );
endinterface

// File: rtl/gauss3x3_engine.sv
// ---------------------------------------------------------------------------
// gauss3x3_engine
//
// Purpose: reads a grayscale image from SRAM port A, applies the 3x3
// Gaussian kernel 1-2-1 / 2-4-2 / 1-2-1 (divided by 16) and writes the
// filtered image to a separate region through SRAM port B. Border pixels
// are copied unchanged.
//
// Ports:
//   clk    single clock for the engine and both SRAM ports
//   rst_n  synchronous active-low reset
//   bus    gauss3x3_engine_if.master: start/busy/done handshake plus
//          SRAM port A (ena, wena, addra, qa) and port B (enb, wenb,
//          addrb, db)
//
// Parameters:
//   IMG_W, IMG_H  image size in pixels (both >= 3)
//   SRC_BASE      10-bit base address of the row-major source image
//   DST_BASE      10-bit base address of the row-major destination image
//
// Configuration macro:
//   GAUSS_ROUND_EN  when defined the result is rounded ((sum + 8) >> 4);
//                   otherwise it is truncated (sum >> 4). Timing is
//                   identical in both builds.
// ---------------------------------------------------------------------------
module gauss3x3_engine #(
    parameter int         IMG_W    = 16,
    parameter int         IMG_H    = 16,
    parameter logic [9:0] SRC_BASE = 10'd0,
    parameter logic [9:0] DST_BASE = 10'd512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gauss3x3_engine_if.master     bus
);

    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam int COL_W = $clog2(IMG_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LAST,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [3:0]         tap_q, tap_d;
    logic [11:0]        sum_q, sum_d;

    logic               is_border;
    logic               last_col;
    logic               last_row;
    logic [3:0]         tap_sel;
    logic [3:0]         tap_off;
    logic [1:0]         prev_shift;
    int                 rd_row;
    int                 rd_col;
    logic [9:0]         rd_addr;
    logic [9:0]         wr_addr;
    logic [11:0]        qa_ext;
    logic [7:0]         result;

    // Tap k (0..8) maps to a {row offset, col offset} pair, each 0..2,
    // where 1 is the centre; tap 4 is the centre pixel itself.
    function automatic logic [3:0] tap_offset(input logic [3:0] k);
        case (k)
            4'd0:    tap_offset = {2'd0, 2'd0};
            4'd1:    tap_offset = {2'd0, 2'd1};
            4'd2:    tap_offset = {2'd0, 2'd2};
            4'd3:    tap_offset = {2'd1, 2'd0};
            4'd4:    tap_offset = {2'd1, 2'd1};
            4'd5:    tap_offset = {2'd1, 2'd2};
            4'd6:    tap_offset = {2'd2, 2'd0};
            4'd7:    tap_offset = {2'd2, 2'd1};
            4'd8:    tap_offset = {2'd2, 2'd2};
            default: tap_offset = {2'd1, 2'd1};
        endcase
    endfunction

    // Kernel weight as a shift: 1-2-1 separable, so each centred axis
    // doubles the weight (corner 1, edge 2, centre 4).
    function automatic logic [1:0] tap_shift(input logic [3:0] k);
        logic [3:0] off;
        off       = tap_offset(k);
        tap_shift = {1'b0, (off[3:2] == 2'd1)} + {1'b0, (off[1:0] == 2'd1)};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tap_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tap_q   <= tap_d;
            sum_q   <= sum_d;
        end
    end

    // Pixel classification and address generation. Border pixels always
    // address the centre tap, so the window never leaves the image.
    always_comb begin
        last_col   = (int'(col_q) == IMG_W - 1);
        last_row   = (int'(row_q) == IMG_H - 1);
        is_border  = (row_q == '0) || last_row || (col_q == '0) || last_col;
        tap_sel    = is_border ? 4'd4 : tap_q;
        tap_off    = tap_offset(tap_sel);
        rd_row     = int'(row_q) + int'(tap_off[3:2]) - 1;
        rd_col     = int'(col_q) + int'(tap_off[1:0]) - 1;
        rd_addr    = SRC_BASE + 10'(rd_row * IMG_W + rd_col);
        wr_addr    = DST_BASE + 10'(int'(row_q) * IMG_W + int'(col_q));
        // Data arriving now belongs to the tap issued one cycle earlier.
        prev_shift = tap_shift(tap_q - 4'd1);
        qa_ext     = {4'b0000, bus.qa};
    end

`ifdef GAUSS_ROUND_EN
    logic [11:0] sum_rnd;
    always_comb begin
        sum_rnd = sum_q + 12'd8;
        result  = sum_rnd[11:4];
    end
`else
    always_comb begin
        result = sum_q[11:4];
    end
`endif

    // Next-state logic: scan pixels row-major, 9-tap read for interior
    // pixels and a single centre read for border pixels.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tap_d   = tap_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_READ;
                    row_d   = '0;
                    col_d   = '0;
                    tap_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_READ: begin
                if (is_border) begin
                    state_d = ST_LAST;
                end else begin
                    if (tap_q != 4'd0) begin
                        sum_d = sum_q + (qa_ext << prev_shift);
                    end
                    if (tap_q == 4'd8) begin
                        tap_d   = '0;
                        state_d = ST_LAST;
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end
            end
            ST_LAST: begin
                // Border copy is scaled by 16 so the common >>4 restores it.
                if (is_border) begin
                    sum_d = qa_ext << 4;
                end else begin
                    sum_d = sum_q + (qa_ext << tap_shift(4'd8));
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                sum_d = '0;
                if (last_col && last_row) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_DONE;
                end else if (last_col) begin
                    col_d   = '0;
                    row_d   = row_q + ROW_W'(1);
                    state_d = ST_READ;
                end else begin
                    col_d   = col_q + COL_W'(1);
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from the registered state, so a reset edge
    // returns every port to its idle value immediately.
    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.ena   = 1'b0;
        bus.wena  = 1'b1;
        bus.addra = '0;
        bus.enb   = 1'b0;
        bus.wenb  = 1'b1;
        bus.addrb = '0;
        bus.db    = '0;
        case (state_q)
            ST_READ: begin
                bus.busy  = 1'b1;
                bus.ena   = 1'b1;
                bus.addra = rd_addr;
            end
            ST_LAST: begin
                bus.busy = 1'b1;
            end
            ST_WRITE: begin
                bus.busy  = 1'b1;
                bus.enb   = 1'b1;
                bus.wenb  = 1'b0;
                bus.addrb = wr_addr;
                bus.db    = result;
            end
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gauss3x3_engine.sv
// ---------------------------------------------------------------------------
// tb_gauss3x3_engine
//
// Purpose: self-checking bench for gauss3x3_engine with a behavioural
// dual-port SRAM. Expected outputs come from hand-computed tables and a
// direct weighted-sum model of the kernel.
//
// Configuration macro: GAUSS_ROUND_EN selects rounded expected values.
// ---------------------------------------------------------------------------
module tb_gauss3x3_engine;

    localparam int W        = 16;
    localparam int H        = 16;
    localparam int DST      = 512;
    localparam int RUN_BUSY = 2336;

`ifdef GAUSS_ROUND_EN
    localparam int C4 = 64;
    localparam int C2 = 32;
    localparam int C1 = 16;
`else
    localparam int C4 = 63;
    localparam int C2 = 31;
    localparam int C1 = 15;
`endif

    typedef struct {
        int row;
        int col;
        int expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic load_req;

    logic [7:0] mem     [0:1023];
    logic [7:0] img_buf [0:1023];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int write_cnt = 0;
    int proto_err = 0;

    vec_t imp_vec [8];
    vec_t brd_vec [2];

    always #5 clk = ~clk;

    gauss3x3_engine_if bus_if ();

    gauss3x3_engine #(
        .IMG_W    (W),
        .IMG_H    (H),
        .SRC_BASE (10'd0),
        .DST_BASE (10'd512)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Behavioural dual-port SRAM with a one-cycle bulk load path.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 1024; i++) mem[i] <= img_buf[i];
        end else if (bus_if.enb && !bus_if.wenb) begin
            mem[bus_if.addrb] <= bus_if.db;
        end
        if (bus_if.ena) bus_if.qa <= mem[bus_if.addra];
    end

    // Port monitor: counts busy cycles, done pulses, writes and any port
    // protocol violation.
    always @(negedge clk) begin
        busy_cnt  <= busy_cnt + (bus_if.busy ? 1 : 0);
        done_cnt  <= done_cnt + (bus_if.done ? 1 : 0);
        write_cnt <= write_cnt + ((bus_if.enb && !bus_if.wenb) ? 1 : 0);
        if ((bus_if.wena !== 1'b1) ||
            (!bus_if.wenb && !bus_if.enb) ||
            (bus_if.ena && bus_if.enb) ||
            (bus_if.ena && !bus_if.busy) ||
            (bus_if.enb && !bus_if.wenb &&
             ((int'(bus_if.addrb) < 512) || (int'(bus_if.addrb) > 767))))
            proto_err <= proto_err + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic load_image();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic fill_image(input int val);
        for (int i = 0; i < 1024; i++) img_buf[i] = (i < 256) ? 8'(val) : 8'hEE;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) img_buf[i] = (i < 256) ? 8'($urandom_range(255)) : 8'hEE;
    endtask

    task automatic run_to_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus_if.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Full run from IDLE: start, wait for done, then check cycle, pulse
    // and write counts once back in IDLE.
    task automatic run_image(input string tag);
        int b0, d0, w0;
        bit ok;
        b0 = busy_cnt;
        d0 = done_cnt;
        w0 = write_cnt;
        applyStimulus();
        run_to_done(ok);
        checkOutput({tag, "_done_seen"}, int'(ok), 1);
        @(negedge clk);
        checkOutput({tag, "_busy_cycles"}, busy_cnt - b0, RUN_BUSY);
        checkOutput({tag, "_done_pulses"}, done_cnt - d0, 1);
        checkOutput({tag, "_writes"}, write_cnt - w0, 256);
    endtask

    function automatic int expect_pixel(input int r, input int c);
        int s;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return int'(img_buf[r * W + c]);
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += int'(img_buf[(r + dr) * W + c + dc]) * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
`ifdef GAUSS_ROUND_EN
        return (s + 8) / 16;
`else
        return s / 16;
`endif
    endfunction

    task automatic check_image(input string tag);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                checkOutput($sformatf("%s(%0d,%0d)", tag, r, c), int'(mem[DST + r * W + c]), expect_pixel(r, c));
    endtask

    initial begin
        int b0, d0, w0, k;
        bit ok;

        imp_vec[0] = '{5, 5, C4};
        imp_vec[1] = '{4, 5, C2};
        imp_vec[2] = '{6, 5, C2};
        imp_vec[3] = '{5, 4, C2};
        imp_vec[4] = '{4, 4, C1};
        imp_vec[5] = '{6, 6, C1};
        imp_vec[6] = '{7, 7, 0};
        imp_vec[7] = '{3, 5, 0};
        brd_vec[0] = '{0, 0, 77};
        brd_vec[1] = '{15, 9, 200};

        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        load_req     = 1'b0;
        fill_image(0);
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_busy", int'(bus_if.busy), 0);
        checkOutput("rst_done", int'(bus_if.done), 0);
        checkOutput("rst_ena", int'(bus_if.ena), 0);
        checkOutput("rst_wena", int'(bus_if.wena), 1);
        checkOutput("rst_addra", int'(bus_if.addra), 0);
        checkOutput("rst_enb", int'(bus_if.enb), 0);
        checkOutput("rst_wenb", int'(bus_if.wenb), 1);
        checkOutput("rst_addrb", int'(bus_if.addrb), 0);
        checkOutput("rst_db", int'(bus_if.db), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", int'(bus_if.busy), 0);

        $display("[TB] flat image");
        fill_image(100);
        load_image();
        run_image("flat");
        for (int i = 0; i < 256; i++)
            checkOutput($sformatf("flat_px%0d", i), int'(mem[DST + i]), 100);

        $display("[TB] impulse image");
        fill_image(0);
        img_buf[5 * W + 5] = 8'd255;
        load_image();
        run_image("impulse");
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("impulse(%0d,%0d)", imp_vec[i].row, imp_vec[i].col),
                        int'(mem[DST + imp_vec[i].row * W + imp_vec[i].col]), imp_vec[i].expected);

        $display("[TB] border copy with random interior");
        fill_random();
        img_buf[0]          = 8'd77;
        img_buf[15 * W + 9] = 8'd200;
        load_image();
        run_image("border");
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("border(%0d,%0d)", brd_vec[i].row, brd_vec[i].col),
                        int'(mem[DST + brd_vec[i].row * W + brd_vec[i].col]), brd_vec[i].expected);
        check_image("rand");

        $display("[TB] start pulses during run and in done");
        fill_random();
        load_image();
        b0 = busy_cnt;
        d0 = done_cnt;
        w0 = write_cnt;
        applyStimulus();
        k  = 1;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            k++;
            if (bus_if.done) begin
                ok = 1'b1;
                bus_if.start = 1'b1;
                break;
            end
            bus_if.start = (k == 10 || k == 2000);
        end
        checkOutput("pulse_done_seen", int'(ok), 1);
        @(negedge clk);
        checkOutput("start_in_done_busy", int'(bus_if.busy), 0);
        checkOutput("start_in_done_done", int'(bus_if.done), 0);
        checkOutput("pulse_busy_cycles", busy_cnt - b0, RUN_BUSY);
        checkOutput("pulse_done_pulses", done_cnt - d0, 1);
        checkOutput("pulse_writes", write_cnt - w0, 256);
        check_image("pulse");
        b0 = busy_cnt;
        d0 = done_cnt;
        w0 = write_cnt;
        @(negedge clk);
        bus_if.start = 1'b0;
        checkOutput("start_in_idle_busy", int'(bus_if.busy), 1);
        run_to_done(ok);
        checkOutput("rerun_done_seen", int'(ok), 1);
        @(negedge clk);
        checkOutput("rerun_busy_cycles", busy_cnt - b0, RUN_BUSY);
        checkOutput("rerun_done_pulses", done_cnt - d0, 1);
        checkOutput("rerun_writes", write_cnt - w0, 256);

        $display("[TB] reset mid-run and restart");
        fill_random();
        load_image();
        applyStimulus();
        for (int i = 2; i <= 500; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_busy", int'(bus_if.busy), 0);
        checkOutput("midrst_enb", int'(bus_if.enb), 0);
        checkOutput("midrst_wenb", int'(bus_if.wenb), 1);
        checkOutput("midrst_done", int'(bus_if.done), 0);
        w0 = write_cnt;
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        checkOutput("midrst_no_writes", write_cnt - w0, 0);
        checkOutput("midrst_no_done", done_cnt - d0, 0);
        checkOutput("midrst_idle", int'(bus_if.busy), 0);
        load_image();
        run_image("restart");
        check_image("restart");

        checkOutput("protocol_violations", proto_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
